// File: rtl/alu_pkg.sv
// Shared decode constants and FSM state type for the alu_muldiv execute stage.
package alu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_M   = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue and result handshakes of the alu_muldiv execute stage.
interface alu_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] in_1;
  logic [XLEN-1:0] in_2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            dm_enable;
  logic            dm_write;
  logic            busy;

  modport master (
    output in_valid, instr, in_1, in_2, out_ready,
    input  in_ready, out_valid, result, zero, dm_enable, dm_write, busy
  );

  modport slave (
    input  in_valid, instr, in_1, in_2, out_ready,
    output in_ready, out_valid, result, zero, dm_enable, dm_write, busy
  );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider on operand magnitudes; one quotient bit per cycle,
// signs and divide-by-zero results applied on the final step.
module alu_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  logic             active_r, q_neg_r, r_neg_r, dz_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  quo_r, rem_r, div_r, dividend_r;
  logic             a_neg_s, b_neg_s;
  logic [XLEN:0]    shifted_s;
  logic [XLEN+1:0]  diff_s;
  logic [XLEN-1:0]  quo_nx_s, rem_nx_s;
  logic             unused_diff_s;

  assign a_neg_s       = is_signed && dividend[XLEN-1];
  assign b_neg_s       = is_signed && divisor[XLEN-1];
  assign shifted_s     = {rem_r, quo_r[XLEN-1]};
  assign diff_s        = {1'b0, shifted_s} - {2'b00, div_r};
  assign unused_diff_s = diff_s[XLEN];

  // One restoring step: keep the trial subtraction only when it did not go negative.
  always_comb begin
    rem_nx_s = shifted_s[XLEN-1:0];
    quo_nx_s = {quo_r[XLEN-2:0], 1'b0};
    if (!diff_s[XLEN+1]) begin
      rem_nx_s = diff_s[XLEN-1:0];
      quo_nx_s = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      rem_nx_s = shifted_s[XLEN-1:0];
      quo_nx_s = {quo_r[XLEN-2:0], 1'b0};
    end
  end

  assign done      = active_r && (cnt_r == CNT_W'(1));
  assign quotient  = dz_r ? {XLEN{1'b1}} : (q_neg_r ? (-quo_nx_s) : quo_nx_s);
  assign remainder = dz_r ? dividend_r   : (r_neg_r ? (-rem_nx_s) : rem_nx_s);

  // Operand capture on start, then XLEN iterations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r   <= 1'b0;
      cnt_r      <= '0;
      quo_r      <= '0;
      rem_r      <= '0;
      div_r      <= '0;
      dividend_r <= '0;
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      dz_r       <= 1'b0;
    end else if (start) begin
      active_r   <= 1'b1;
      cnt_r      <= CNT_W'(XLEN);
      quo_r      <= a_neg_s ? (-dividend) : dividend;
      rem_r      <= '0;
      div_r      <= b_neg_s ? (-divisor) : divisor;
      dividend_r <= dividend;
      q_neg_r    <= a_neg_s ^ b_neg_s;
      r_neg_r    <= a_neg_s;
      dz_r       <= (divisor == '0);
    end else if (active_r) begin
      cnt_r    <= cnt_r - CNT_W'(1);
      quo_r    <= quo_nx_s;
      rem_r    <= rem_nx_s;
      active_r <= (cnt_r != CNT_W'(1));
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with iterative RV32M multiply/divide behind valid/ready handshakes.
// Define ALU_FAST_MUL_EN to replace the iterative multiplier by a single-cycle one.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic         clk,
  input logic         rst,
  alu_muldiv_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  logic [6:0]       opcode_s, funct7_s;
  logic [2:0]       funct3_s;
  logic             unused_instr_s;
  state_e           state_r, state_next_s;
  logic [CNT_W-1:0] counter_r;
  logic             out_valid_r, busy_r, zero_r, dm_enable_r, dm_write_r, div_rem_r;
  logic [XLEN-1:0]  result_r;
  logic             in_ready_s, accept_s, m_op_s, mul_op_s, div_op_s;
  logic             start_mul_s, start_div_s, mul_fin_s, div_fin_s, div_done_s;
  logic [XLEN-1:0]  alu_res_s, fast_mul_s, mul_res_s, div_q_s, div_r_s, div_res_s;
  logic             alu_zero_s, dm_en_s, dm_wr_s, eq_s, lt_s, ltu_s;

  assign opcode_s       = bus.instr[6:0];
  assign funct3_s       = bus.instr[14:12];
  assign funct7_s       = bus.instr[31:25];
  assign unused_instr_s = ^{bus.instr[24:15], bus.instr[11:7]};

  assign in_ready_s  = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign m_op_s      = (opcode_s == OP_R) && (funct7_s == FUNCT7_M);
  assign div_op_s    = m_op_s && funct3_s[2];
  assign mul_op_s    = m_op_s && !funct3_s[2];
  assign start_div_s = accept_s && div_op_s;
  assign mul_fin_s   = (state_r == MUL) && (counter_r == CNT_W'(1));
  assign div_fin_s   = (state_r == DIV) && div_done_s;

  assign eq_s  = (bus.in_1 == bus.in_2);
  assign lt_s  = ($signed(bus.in_1) < $signed(bus.in_2));
  assign ltu_s = (bus.in_1 < bus.in_2);

  function automatic logic [XLEN-1:0] alu_op(input logic [2:0] f3, input logic sub,
                                             input logic sra, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (f3)
      F3_ADD:  alu_op = sub ? (a - b) : (a + b);
      F3_SLL:  alu_op = a << sh;
      F3_SLT:  alu_op = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      F3_SLTU: alu_op = {{(XLEN-1){1'b0}}, (a < b)};
      F3_XOR:  alu_op = a ^ b;
      F3_SR: begin
        if (sra) alu_op = $signed(a) >>> sh;
        else     alu_op = a >> sh;
      end
      F3_OR:   alu_op = a | b;
      F3_AND:  alu_op = a & b;
      default: alu_op = '0;
    endcase
  endfunction

`ifdef ALU_FAST_MUL_EN
  logic signed [XLEN:0]     fa_s, fb_s;
  logic signed [2*XLEN+1:0] fprod_s;
  logic                     unused_fprod_s;
  assign start_mul_s    = 1'b0;
  assign fa_s           = {(funct3_s != F3_MULHU) && bus.in_1[XLEN-1], bus.in_1};
  assign fb_s           = {((funct3_s == F3_MUL) || (funct3_s == F3_MULH)) && bus.in_2[XLEN-1], bus.in_2};
  assign fprod_s        = fa_s * fb_s;
  assign unused_fprod_s = ^fprod_s[2*XLEN+1:2*XLEN];
  assign fast_mul_s     = (funct3_s == F3_MUL) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
  assign mul_res_s      = '0;
`else
  logic [2*XLEN-1:0] mcand_r, prod_r, prod_step_s, prod_final_s;
  logic [XLEN-1:0]   mplier_r;
  logic              mul_neg_r, mul_hi_r, mul_a_neg_s, mul_b_neg_s;
  assign start_mul_s  = accept_s && mul_op_s;
  assign fast_mul_s   = '0;
  assign mul_a_neg_s  = (funct3_s != F3_MULHU) && bus.in_1[XLEN-1];
  assign mul_b_neg_s  = ((funct3_s == F3_MUL) || (funct3_s == F3_MULH)) && bus.in_2[XLEN-1];
  assign prod_step_s  = prod_r + (mplier_r[0] ? mcand_r : '0);
  assign prod_final_s = mul_neg_r ? (-prod_step_s) : prod_step_s;
  assign mul_res_s    = mul_hi_r ? prod_final_s[2*XLEN-1:XLEN] : prod_final_s[XLEN-1:0];

  // Shift-add multiplier on magnitudes; the sign is folded in on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r   <= '0;
      mplier_r  <= '0;
      prod_r    <= '0;
      mul_neg_r <= 1'b0;
      mul_hi_r  <= 1'b0;
    end else if (start_mul_s) begin
      mcand_r   <= {{XLEN{1'b0}}, (mul_a_neg_s ? (-bus.in_1) : bus.in_1)};
      mplier_r  <= mul_b_neg_s ? (-bus.in_2) : bus.in_2;
      prod_r    <= '0;
      mul_neg_r <= mul_a_neg_s ^ mul_b_neg_s;
      mul_hi_r  <= (funct3_s != F3_MUL);
    end else if (state_r == MUL) begin
      prod_r   <= prod_step_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end
  end
`endif

  alu_divider #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_div_s),
    .is_signed (!funct3_s[0]),
    .dividend  (bus.in_1),
    .divisor   (bus.in_2),
    .done      (div_done_s),
    .quotient  (div_q_s),
    .remainder (div_r_s)
  );
  assign div_res_s = div_rem_r ? div_r_s : div_q_s;

  // Single-cycle result, branch flag and memory strobes for the issuing instruction.
  always_comb begin
    alu_res_s  = '0;
    alu_zero_s = 1'b0;
    dm_en_s    = 1'b0;
    dm_wr_s    = 1'b0;
    case (opcode_s)
      OP_R: begin
        if (m_op_s) alu_res_s = fast_mul_s;
        else alu_res_s = alu_op(funct3_s, funct7_s == FUNCT7_ALT, funct7_s == FUNCT7_ALT,
                                bus.in_1, bus.in_2);
      end
      OP_I: alu_res_s = alu_op(funct3_s, 1'b0, funct7_s == FUNCT7_ALT, bus.in_1, bus.in_2);
      OP_LOAD: begin
        alu_res_s = bus.in_1 + bus.in_2;
        dm_en_s   = 1'b1;
      end
      OP_STORE: begin
        alu_res_s = bus.in_1 + bus.in_2;
        dm_en_s   = 1'b1;
        dm_wr_s   = 1'b1;
      end
      OP_BRANCH: begin
        case (funct3_s)
          F3_BEQ:  alu_zero_s = eq_s;
          F3_BNE:  alu_zero_s = !eq_s;
          F3_BLT:  alu_zero_s = lt_s;
          F3_BGE:  alu_zero_s = !lt_s;
          F3_BLTU: alu_zero_s = ltu_s;
          F3_BGEU: alu_zero_s = !ltu_s;
          default: alu_zero_s = 1'b0;
        endcase
      end
      OP_LUI:  alu_res_s = bus.in_2;
      default: alu_res_s = '0;
    endcase
  end

  // FSM next state: stay in MUL/DIV until the last iteration completes.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_mul_s)      state_next_s = MUL;
        else if (start_div_s) state_next_s = DIV;
        else                  state_next_s = IDLE;
      end
      MUL: begin
        if (mul_fin_s) state_next_s = IDLE;
        else           state_next_s = MUL;
      end
      DIV: begin
        if (div_done_s) state_next_s = IDLE;
        else            state_next_s = DIV;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Iteration counter and remainder/quotient select for the pending divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_r <= '0;
      div_rem_r <= 1'b0;
    end else if (start_mul_s || start_div_s) begin
      counter_r <= CNT_W'(XLEN);
      div_rem_r <= funct3_s[1];
    end else if (state_r != IDLE) begin
      counter_r <= counter_r - CNT_W'(1);
    end
  end

  // Output register: loads on a simple accept or iteration end, otherwise holds until drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r    <= '0;
      zero_r      <= 1'b0;
      dm_enable_r <= 1'b0;
      dm_write_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s && !start_mul_s && !start_div_s) begin
      result_r    <= alu_res_s;
      zero_r      <= alu_zero_s;
      dm_enable_r <= dm_en_s;
      dm_write_r  <= dm_wr_s;
      out_valid_r <= 1'b1;
    end else if (mul_fin_s || div_fin_s) begin
      result_r    <= mul_fin_s ? mul_res_s : div_res_s;
      zero_r      <= 1'b0;
      dm_enable_r <= 1'b0;
      dm_write_r  <= 1'b0;
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.dm_enable = dm_enable_r;
  assign bus.dm_write  = dm_write_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at XLEN=32 (default build).
module tb_alu_muldiv;
  import alu_pkg::*;

  logic clk, rst;
  int   checks, errors;

  alu_muldiv_if #(.XLEN(32)) bus ();
  alu_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.instr    = ins;
    bus.in_1     = a;
    bus.in_2     = b;
    bus.in_valid = 1'b1;
  endtask

  // Presents one operation, waits for in_ready, returns #1 after the accept edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    drive(ins, a, b);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles from accept to out_valid and notes any cycle without busy=1/in_ready=0.
  task automatic wait_done(output int lat, output int busy_bad);
    lat = 1;
    busy_bad = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_result: got %h want 0", bus.result); end
    checks++;
    if ({bus.zero, bus.dm_enable, bus.dm_write} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {bus.zero, bus.dm_enable, bus.dm_write});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_alu();
    logic [31:0] ins [14];
    logic [31:0] a [14];
    logic [31:0] b [14];
    logic [31:0] exp [14];
    ins = '{enc(7'h00, F3_ADD, OP_R), enc(FUNCT7_ALT, F3_ADD, OP_R), enc(7'h00, F3_SLT, OP_R),
            enc(7'h00, F3_SLTU, OP_R), enc(FUNCT7_ALT, F3_SR, OP_R), enc(7'h00, F3_SR, OP_R),
            enc(FUNCT7_ALT, F3_SR, OP_I), enc(7'h00, F3_SLL, OP_R), enc(7'h00, F3_XOR, OP_R),
            enc(7'h00, F3_OR, OP_R), enc(7'h00, F3_AND, OP_R), enc(FUNCT7_ALT, F3_ADD, OP_I),
            enc(7'h12, 3'b101, OP_LUI), enc(7'h00, F3_ADD, 7'b1111111)};
    a   = '{32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000,
            32'd1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd10, 32'd9, 32'd3};
    b   = '{32'd4, 32'd7, 32'd1, 32'd1, 32'd4, 32'd4, 32'd4, 32'd33, 32'hFF00FF00, 32'h0F0F0000,
            32'hFF00FF00, 32'd5, 32'h12345000, 32'd4};
    exp = '{32'd7, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h08000000, 32'hF8000000, 32'd2,
            32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000, 32'd15, 32'h12345000, 32'h0};
    for (int i = 0; i < 14; i++) begin
      issue(ins[i], a[i], b[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp[i]) begin
        errors++;
        $display("FAIL alu_vec%0d: valid=%b result=%h want valid=1 result=%h", i, bus.out_valid, bus.result, exp[i]);
      end
      checks++;
      if ({bus.zero, bus.dm_enable, bus.dm_write} !== 3'b000) begin
        errors++; $display("FAIL alu_flags%0d: got %b want 000", i, {bus.zero, bus.dm_enable, bus.dm_write});
      end
    end
  endtask

  task automatic test_branch_mem();
    logic [31:0] ins [9];
    logic [31:0] a [9];
    logic [31:0] b [9];
    logic [31:0] exp [9];
    logic [2:0]  flg [9];
    ins = '{enc(7'h00, F3_BGE, OP_BRANCH), enc(7'h00, F3_BLTU, OP_BRANCH), enc(7'h00, F3_BEQ, OP_BRANCH),
            enc(7'h00, F3_BNE, OP_BRANCH), enc(7'h00, F3_BLT, OP_BRANCH), enc(7'h00, F3_BGEU, OP_BRANCH),
            enc(7'h00, 3'b010, OP_BRANCH), enc(7'h00, 3'b010, OP_STORE), enc(7'h00, 3'b010, OP_LOAD)};
    a   = '{32'hFFFFFFFF, 32'd1, 32'd5, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 32'h100, 32'h200};
    b   = '{32'd0, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd0, 32'd1, 32'd5, 32'd8, 32'hFFFFFFFC};
    exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h108, 32'h1FC};
    flg = '{3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b011, 3'b010};
    for (int i = 0; i < 9; i++) begin
      issue(ins[i], a[i], b[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp[i] ||
          {bus.zero, bus.dm_enable, bus.dm_write} !== flg[i]) begin
        errors++;
        $display("FAIL brmem_vec%0d: valid=%b result=%h flags=%b want result=%h flags=%b", i,
                 bus.out_valid, bus.result, {bus.zero, bus.dm_enable, bus.dm_write}, exp[i], flg[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(enc(7'h00, F3_ADD, OP_R), 32'd1, 32'd2);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd3) begin
      errors++; $display("FAIL b2b_first: valid=%b result=%h want 1/00000003", bus.out_valid, bus.result);
    end
    drive(enc(FUNCT7_ALT, F3_ADD, OP_R), 32'd10, 32'd4);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd6) begin
      errors++; $display("FAIL b2b_second: valid=%b result=%h want 1/00000006", bus.out_valid, bus.result);
    end
    drive(enc(7'h00, F3_XOR, OP_R), 32'h0000FFFF, 32'h00FF00FF);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h00FFFF00) begin
      errors++; $display("FAIL b2b_third: valid=%b result=%h want 1/00ffff00", bus.out_valid, bus.result);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] exp [4];
    int lat, bad;
    f3  = '{F3_MULH, F3_MULHU, F3_MUL, F3_MULHSU};
    a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF};
    b   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
    exp = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFEB, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      issue(enc(FUNCT7_M, f3[i], OP_R), a[i], b[i]);
      wait_done(lat, bad);
      checks++;
      if (lat != 33) begin errors++; $display("FAIL mul_latency%0d: got %0d want 33", i, lat); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL mul_busy%0d: %0d bad cycles want 0", i, bad); end
      checks++;
      if (bus.result !== exp[i]) begin
        errors++; $display("FAIL mul_result%0d: got %h want %h", i, bus.result, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [9];
    logic [31:0] a [9];
    logic [31:0] b [9];
    logic [31:0] exp [9];
    int lat, bad;
    f3  = '{F3_DIV, F3_REM, F3_DIV, F3_REM, F3_REM, F3_DIV, F3_DIVU, F3_REMU, F3_DIVU};
    a   = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFEC, 32'd100, 32'd100, 32'd7};
    b   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd7, 32'd7, 32'd0};
    exp = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'd14, 32'd2, 32'hFFFFFFFF};
    for (int i = 0; i < 9; i++) begin
      issue(enc(FUNCT7_M, f3[i], OP_R), a[i], b[i]);
      wait_done(lat, bad);
      checks++;
      if (lat != 33 || bad != 0) begin
        errors++; $display("FAIL div_timing%0d: latency %0d bad %0d want 33/0", i, lat, bad);
      end
      checks++;
      if (bus.result !== exp[i]) begin
        errors++; $display("FAIL div_result%0d: got %h want %h", i, bus.result, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    issue(enc(7'h00, F3_ADD, OP_R), 32'd20, 32'd22);
    drive(enc(FUNCT7_ALT, F3_ADD, OP_R), 32'd9, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd42 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b result=%h in_ready=%b want 1/0000002a/0", i,
                 bus.out_valid, bus.result, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin
      errors++; $display("FAIL hold_release: valid=%b result=%h want 1/00000005", bus.out_valid, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(enc(FUNCT7_M, F3_DIV, OP_R), 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: valid=%b busy=%b in_ready=%b want 0/0/1", bus.out_valid, bus.busy, bus.in_ready);
    end
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_output: %0d valid cycles want 0", seen); end
    issue(enc(7'h00, F3_ADD, OP_R), 32'd2, 32'd2);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd4) begin
      errors++; $display("FAIL midrst_recover: valid=%b result=%h want 1/00000004", bus.out_valid, bus.result);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.in_1      = 32'h0;
    bus.in_2      = 32'h0;
    bus.out_ready = 1'b1;
    #2;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_alu();
    test_branch_mem();
    test_back_to_back();
    test_mul();
    test_div();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
